// File: rtl/vermibus_timer_pkg.sv
// rtl/vermibus_timer_pkg.sv - shared types, register map and bus byte helpers for vermibus_timer
package vermibus_timer_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  wstrobe_t;
    typedef logic [2:0]  reg_idx_t;

    localparam reg_idx_t TIMER_CONTROL  = 3'd0;
    localparam reg_idx_t TIMER_LIMIT    = 3'd1;
    localparam reg_idx_t TIMER_COUNT    = 3'd2;
    localparam reg_idx_t TIMER_STATUS   = 3'd3;
    localparam reg_idx_t TIMER_PRESCALE = 3'd4;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;

    localparam word_t CTRL_MASK   = 32'h0000_0007;
    localparam word_t STATUS_MASK = 32'h0000_0001;

    typedef enum logic {
        IDLE,
        ACK
    } resp_state_e;

    function automatic word_t byte_merge(input word_t old_w, input word_t new_w, input wstrobe_t strb);
        word_t r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Write-1-to-clear restricted to the strobed byte lanes.
    function automatic word_t byte_clear(input word_t old_w, input word_t clr_w, input wstrobe_t strb);
        word_t r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = old_w[8*b +: 8] & ~clr_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/vermibus_timer_if.sv
// rtl/vermibus_timer_if.sv - Vermibus request/response bus with master and slave modports
interface vermibus_timer_if
    import vermibus_timer_pkg::*;
();
    logic     valid;
    word_t    address;
    wstrobe_t wstrobe;
    word_t    wdata;
    logic     ready;
    word_t    rdata;
    logic     irq;

    modport master (
        output valid, address, wstrobe, wdata,
        input  ready, rdata, irq
    );

    modport slave (
        input  valid, address, wstrobe, wdata,
        output ready, rdata, irq
    );
endinterface

// File: rtl/vermibus_timer_tick.sv
// rtl/vermibus_timer_tick.sv - prescaler tick generator, built only with VERMIBUS_TIMER_PRESCALER_EN
`ifdef VERMIBUS_TIMER_PRESCALER_EN
module vermibus_timer_tick
    import vermibus_timer_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  enable_i,
    input  word_t prescale_i,
    input  logic  prescale_wr_i,
    output logic  tick_o
);

    word_t pcnt_q, pcnt_d;

    assign tick_o = enable_i && (pcnt_q == prescale_i);

    always_comb begin
        pcnt_d = pcnt_q + 32'd1;
        if (!enable_i || prescale_wr_i || tick_o) pcnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pcnt_q <= '0;
        else        pcnt_q <= pcnt_d;
    end

endmodule
`endif

// File: rtl/vermibus_timer.sv
// rtl/vermibus_timer.sv - memory-mapped up-counting timer with one-wait-state Vermibus response
// Optional PRESCALE register and prescaler enabled by defining VERMIBUS_TIMER_PRESCALER_EN.
module vermibus_timer
    import vermibus_timer_pkg::*;
#(
    parameter word_t RESET_LIMIT = 32'hFFFF_FFFF,
    parameter int    ADDR_LSB    = 2
) (
    input  logic clk,
    input  logic reset,
    vermibus_timer_if.slave bus
);

    resp_state_e state_q, state_d;
    logic        ready_q, ready_d;
    word_t       rdata_q, rdata_d;
    word_t       ctrl_q, ctrl_d;
    word_t       limit_q, limit_d;
    word_t       count_q, count_d;
    word_t       status_q, status_d;
    logic        irq_q, irq_d;
    word_t       rd_word;
    reg_idx_t    idx;
    logic        wr_en;
    logic        tick;
    logic        terminal;

    assign idx      = bus.address[ADDR_LSB+2:ADDR_LSB];
    assign wr_en    = (state_q == IDLE) && bus.valid && (bus.wstrobe != '0);
    assign terminal = tick && (count_q == limit_q);

`ifdef VERMIBUS_TIMER_PRESCALER_EN
    word_t prescale_q, prescale_d;
    logic  prescale_wr;

    assign prescale_wr = wr_en && (idx == TIMER_PRESCALE);

    always_comb begin
        prescale_d = prescale_q;
        if (prescale_wr) prescale_d = byte_merge(prescale_q, bus.wdata, bus.wstrobe);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prescale_q <= '0;
        else        prescale_q <= prescale_d;
    end

    vermibus_timer_tick u_tick (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (ctrl_q[CTRL_ENABLE]),
        .prescale_i    (prescale_q),
        .prescale_wr_i (prescale_wr),
        .tick_o        (tick)
    );
`else
    assign tick = ctrl_q[CTRL_ENABLE];
`endif

    always_comb begin
        rd_word = '0;
        case (idx)
            TIMER_CONTROL:  rd_word = ctrl_q;
            TIMER_LIMIT:    rd_word = limit_q;
            TIMER_COUNT:    rd_word = count_q;
            TIMER_STATUS:   rd_word = status_q;
`ifdef VERMIBUS_TIMER_PRESCALER_EN
            TIMER_PRESCALE: rd_word = prescale_q;
`endif
            default:        rd_word = '0;
        endcase
    end

    // Counter effects are computed first so a same-cycle bus write overrides them.
    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        rdata_d  = rdata_q;
        ctrl_d   = ctrl_q;
        limit_d  = limit_q;
        count_d  = count_q;
        status_d = status_q;
        irq_d    = status_q[0] & ctrl_q[CTRL_IRQ_EN];

        if (tick) begin
            if (terminal) begin
                count_d = '0;
                if (!ctrl_q[CTRL_AUTO_RELOAD]) ctrl_d[CTRL_ENABLE] = 1'b0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    state_d = ACK;
                    ready_d = 1'b1;
                    if (bus.wstrobe != '0) begin
                        case (idx)
                            TIMER_CONTROL: ctrl_d   = byte_merge(ctrl_d, bus.wdata, bus.wstrobe) & CTRL_MASK;
                            TIMER_LIMIT:   limit_d  = byte_merge(limit_q, bus.wdata, bus.wstrobe);
                            TIMER_COUNT:   count_d  = byte_merge(count_d, bus.wdata, bus.wstrobe);
                            TIMER_STATUS:  status_d = byte_clear(status_q, bus.wdata, bus.wstrobe) & STATUS_MASK;
                            default:       ;
                        endcase
                    end else begin
                        rdata_d = rd_word;
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A terminal tick beats a same-cycle status clear.
        if (terminal) status_d = status_d | STATUS_MASK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            ctrl_q   <= '0;
            limit_q  <= RESET_LIMIT;
            count_q  <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            ctrl_q   <= ctrl_d;
            limit_q  <= limit_d;
            count_q  <= count_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign bus.irq   = irq_q;

endmodule
